// File: rtl/junction_sequencer.sv
// Master sequencer for the highway/country junction.
// Runs the highway lamp, grants the country road to countryway on a
// synchronised and latched sensor request, hands countryway its green/yellow
// timing, and watchdogs the grant/return handshake.
module junction_sequencer #(
  parameter int unsigned HG_MIN  = 20,
  parameter int unsigned HY_TIME = 4,
  parameter int unsigned AR_TIME = 2,
  parameter int unsigned WD_TIME = 16,
  parameter int unsigned CA_MAX  = 255,
  parameter logic [6:0]  CG_DEF  = 7'd10,
  parameter logic [3:0]  CY_DEF  = 4'd3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor_c,
  input  logic [2:0] out_c,
  input  logic [6:0] cfg_green,
  input  logic [3:0] cfg_yellow,
  output logic [2:0] out_h,
  output logic       sensor_req,
  output logic [6:0] Timeout,
  output logic [3:0] timeout,
  output logic       fault
);

  localparam logic [2:0] H_GREEN  = 3'd0;
  localparam logic [2:0] H_YELLOW = 3'd1;
  localparam logic [2:0] H_ALLRED = 3'd2;
  localparam logic [2:0] C_GRANT  = 3'd3;
  localparam logic [2:0] C_ACTIVE = 3'd4;
  localparam logic [2:0] H_CLEAR  = 3'd5;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  localparam logic [7:0] HG_LAST = 8'(HG_MIN - 1);
  localparam logic [7:0] HY_LAST = 8'(HY_TIME - 1);
  localparam logic [7:0] AR_LAST = 8'(AR_TIME - 1);
  localparam logic [7:0] WD_LAST = 8'(WD_TIME - 1);
  localparam logic [7:0] CA_LAST = 8'(CA_MAX - 1);

  logic [2:0] state;
  logic [2:0] state_nx;
  logic [7:0] cnt;
  logic [1:0] sync_q;
  logic       s_sync;
  logic       req_pend;
  logic       fault_set;
  logic       enter_active;
  logic       enter_grant;

  assign s_sync       = sync_q[1];
  assign enter_active = (state_nx == C_ACTIVE) && (state != C_ACTIVE);
  assign enter_grant  = (state == H_ALLRED) && (state_nx == C_GRANT);

  // Two-flop synchroniser for the asynchronous country sensor
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], sensor_c};
  end

  // Pending request: set by the synchronised sensor, cleared when the country phase starts (clear wins)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          req_pend <= 1'b0;
    else if (enter_active) req_pend <= 1'b0;
    else if (s_sync)       req_pend <= 1'b1;
  end

  // Next-state decode; the watchdog exits also raise fault_set
  always_comb begin
    state_nx  = state;
    fault_set = 1'b0;
    case (state)
      H_GREEN:  if (cnt >= HG_LAST && req_pend) state_nx = H_YELLOW;
      H_YELLOW: if (cnt == HY_LAST) state_nx = H_ALLRED;
      H_ALLRED: if (cnt == AR_LAST) state_nx = C_GRANT;
      C_GRANT: begin
        if (out_c != LAMP_RED) begin
          state_nx = C_ACTIVE;
        end else if (cnt == WD_LAST) begin
          state_nx  = H_CLEAR;
          fault_set = 1'b1;
        end
      end
      C_ACTIVE: begin
        if (out_c == LAMP_RED) begin
          state_nx = H_CLEAR;
        end else if (cnt == CA_LAST) begin
          state_nx  = H_CLEAR;
          fault_set = 1'b1;
        end
      end
      H_CLEAR:  if (cnt == AR_LAST) state_nx = H_GREEN;
      default:  state_nx = H_CLEAR;
    endcase
  end

  // State register and per-state cycle counter (restarts on every state change, saturates)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= H_GREEN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state) cnt <= '0;
      else if (cnt != 8'hFF) cnt <= cnt + 8'd1;
    end
  end

  // Lamp and request are decoded from the next state so they switch on the same edge as state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_h      <= LAMP_GREEN;
      sensor_req <= 1'b0;
    end else begin
      sensor_req <= (state_nx == C_GRANT);
      case (state_nx)
        H_GREEN:  out_h <= LAMP_GREEN;
        H_YELLOW: out_h <= LAMP_YELLOW;
        default:  out_h <= LAMP_RED;
      endcase
    end
  end

  // Country timing is captured only at the grant so countryway sees stable values through its phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Timeout <= CG_DEF;
      timeout <= CY_DEF;
    end else if (enter_grant) begin
      Timeout <= cfg_green;
      timeout <= cfg_yellow;
    end
  end

  // Sticky watchdog flag, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       fault <= 1'b0;
    else if (fault_set) fault <= 1'b1;
  end

endmodule

// File: tb/tb_junction_sequencer.sv
// Scoreboard bench for junction_sequencer. Stimulus pushes the expected
// output segments (value tuple plus length in cycles); the monitor closes a
// segment whenever the sampled outputs change and compares it with the queue head.
module tb_junction_sequencer;

  logic       clk;
  logic       reset_n;
  logic       sensor_c;
  logic [2:0] out_c;
  logic [6:0] cfg_green;
  logic [3:0] cfg_yellow;
  logic [2:0] out_h;
  logic       sensor_req;
  logic [6:0] Timeout;
  logic [3:0] timeout;
  logic       fault;

  junction_sequencer #(
    .HG_MIN (20),
    .HY_TIME(4),
    .AR_TIME(2),
    .WD_TIME(16),
    .CA_MAX (255),
    .CG_DEF (7'd10),
    .CY_DEF (4'd3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sensor_c  (sensor_c),
    .out_c     (out_c),
    .cfg_green (cfg_green),
    .cfg_yellow(cfg_yellow),
    .out_h     (out_h),
    .sensor_req(sensor_req),
    .Timeout   (Timeout),
    .timeout   (timeout),
    .fault     (fault)
  );

  typedef struct packed {
    logic [2:0]  oh;
    logic        req;
    logic        flt;
    logic [6:0]  tg;
    logic [3:0]  ty;
    logic [15:0] len;
  } seg_t;

  seg_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  logic  mon_en = 1'b0;
  logic  cw_en  = 1'b0;
  string tname  = "init";

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void push(logic [2:0] oh, logic req, logic flt,
                               logic [6:0] tg, logic [3:0] ty, int n);
    seg_t s;
    s.oh = oh; s.req = req; s.flt = flt; s.tg = tg; s.ty = ty; s.len = 16'(n);
    sb.push_back(s);
  endfunction

  // Behavioural countryway: on request, green for Timeout cycles, yellow for timeout, then red
  initial begin : countryway
    int st;
    int cnt;
    int yl;
    st = 0; cnt = 0; yl = 0;
    out_c = 3'b100;
    forever begin
      @(negedge clk);
      if (!reset_n || !cw_en) begin
        out_c = 3'b100; st = 0;
      end else begin
        case (st)
          0: if (sensor_req) begin
               out_c = 3'b001; cnt = int'(Timeout); yl = int'(timeout); st = 1;
             end
          1: if (cnt <= 1) begin
               out_c = 3'b010; cnt = yl; st = 2;
             end else cnt--;
          default: if (cnt <= 1) begin
               out_c = 3'b100; st = 0;
             end else cnt--;
        endcase
      end
    end
  end

  // Monitor: measure constant-output segments and check each against the scoreboard
  initial begin : monitor
    logic [15:0] cur;
    logic [15:0] prev;
    int          len;
    bit          started;
    seg_t        e;
    started = 0; len = 0; prev = '0;
    forever begin
      @(negedge clk);
      cur = {out_h, sensor_req, fault, Timeout, timeout};
      if (!mon_en) begin
        started = 0;
      end else if (!started) begin
        prev = cur; len = 1; started = 1;
      end else if (cur !== prev) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected_change got=%h after %0d cycles, required no change",
                   tname, cur, len);
        end else begin
          e = sb.pop_front();
          if ({e.oh, e.req, e.flt, e.tg, e.ty} !== prev || int'(e.len) != len) begin
            errors++;
            $display("FAIL %s segment got oh=%b req=%b flt=%b T=%0d t=%0d len=%0d required oh=%b req=%b flt=%b T=%0d t=%0d len=%0d",
                     tname, prev[15:13], prev[12], prev[11], prev[10:4], prev[3:0], len,
                     e.oh, e.req, e.flt, e.tg, e.ty, e.len);
          end
        end
        prev = cur; len = 1;
      end else begin
        len++;
      end
    end
  end

  task automatic hold_reset();
    mon_en  = 1'b0;
    reset_n = 1'b0;
    sb.delete();
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    mon_en  = 1'b1;
  endtask

  task automatic drain(int limit);
    for (int i = 0; i < limit && sb.size() != 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s drain got %0d pending segments, required 0", tname, sb.size());
      sb.delete();
    end
    mon_en = 1'b0;
  endtask

  task automatic check(string nm, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s %s got=%0h required=%0h", tname, nm, got, exp);
    end
  endtask

  task automatic wait_country_green(int limit);
    int i;
    for (i = 0; i < limit && out_c != 3'b001; i++) @(posedge clk);
    checks++;
    if (out_c != 3'b001) begin
      errors++;
      $display("FAIL %s wait_country_green got out_c=%b required 001 within %0d cycles",
               tname, out_c, limit);
    end
  endtask

  initial begin : stimulus
    reset_n = 1'b0; sensor_c = 1'b0; cfg_green = 7'd10; cfg_yellow = 4'd3;

    // Reset values
    tname = "reset";
    @(posedge clk); #2;
    check("out_h", 16'(out_h), 16'h1);
    check("sensor_req", 16'(sensor_req), 16'h0);
    check("fault", 16'(fault), 16'h0);
    check("Timeout", 16'(Timeout), 16'd10);
    check("timeout", 16'(timeout), 16'd3);

    // No request: highway stays green
    tname = "idle";
    hold_reset(); cw_en = 1'b1;
    release_reset();
    repeat (200) @(posedge clk);
    #2;
    check("out_h", 16'(out_h), 16'h1);
    check("sensor_req", 16'(sensor_req), 16'h0);
    mon_en = 1'b0;

    // Full cycle with countryway, then cfg change mid-phase served at the next grant
    tname = "phase";
    hold_reset(); cw_en = 1'b1; sensor_c = 1'b1; cfg_green = 7'd10; cfg_yellow = 4'd3;
    push(3'b001, 0, 0, 7'd10, 4'd3, 20);
    push(3'b010, 0, 0, 7'd10, 4'd3, 4);
    push(3'b100, 0, 0, 7'd10, 4'd3, 2);
    push(3'b100, 1, 0, 7'd10, 4'd3, 1);
    push(3'b100, 0, 0, 7'd10, 4'd3, 15);
    push(3'b001, 0, 0, 7'd10, 4'd3, 20);
    push(3'b010, 0, 0, 7'd10, 4'd3, 4);
    push(3'b100, 0, 0, 7'd10, 4'd3, 2);
    push(3'b100, 1, 0, 7'd50, 4'd5, 1);
    push(3'b100, 0, 0, 7'd50, 4'd5, 57);
    release_reset();
    wait_country_green(100);
    cfg_green = 7'd50; cfg_yellow = 4'd5;
    drain(400);
    sensor_c = 1'b0;

    // Countryway never answers: watchdog, fault, return to green
    tname = "watchdog";
    hold_reset(); cw_en = 1'b0; sensor_c = 1'b1; cfg_green = 7'd7; cfg_yellow = 4'd9;
    push(3'b001, 0, 0, 7'd10, 4'd3, 20);
    push(3'b010, 0, 0, 7'd10, 4'd3, 4);
    push(3'b100, 0, 0, 7'd10, 4'd3, 2);
    push(3'b100, 1, 0, 7'd7, 4'd9, 16);
    push(3'b100, 0, 1, 7'd7, 4'd9, 2);
    release_reset();
    drain(200);

    // Asynchronous reset in the middle of a country phase, with fault still set
    tname = "async_reset";
    cw_en = 1'b1;
    wait_country_green(200);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("out_h", 16'(out_h), 16'h1);
    check("sensor_req", 16'(sensor_req), 16'h0);
    check("fault", 16'(fault), 16'h0);
    check("Timeout", 16'(Timeout), 16'd10);
    sensor_c = 1'b0;

    // Short pulse early in green: latched, yellow still waits for minimum green
    tname = "early_pulse";
    hold_reset(); cw_en = 1'b1;
    push(3'b001, 0, 0, 7'd10, 4'd3, 20);
    push(3'b010, 0, 0, 7'd10, 4'd3, 4);
    release_reset();
    repeat (5) @(posedge clk);
    #2 sensor_c = 1'b1;
    @(posedge clk);
    #2 sensor_c = 1'b0;
    drain(100);

    // Pulse after minimum green: yellow follows the synchroniser and latch delay
    tname = "late_pulse";
    hold_reset(); cw_en = 1'b1;
    push(3'b001, 0, 0, 7'd10, 4'd3, 34);
    push(3'b010, 0, 0, 7'd10, 4'd3, 4);
    release_reset();
    repeat (30) @(posedge clk);
    #2 sensor_c = 1'b1;
    @(posedge clk);
    #2 sensor_c = 1'b0;
    drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
